// File: rtl/core_pkg.sv
// Shared core parameters for the pipeline stages.
// Latency: n/a (constants only).
// Backpressure: n/a.
package core_pkg;
    localparam int WORD_LEN        = 8;
    localparam int ADDR_LEN        = 8;
    localparam int INSTRUCTION_LEN = 19;
    localparam int PC_LEN          = 12;
    localparam int STACK_DEPTH     = 8;
endpackage : core_pkg

// File: rtl/mem_stage_wb_reg_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline never stalls at this stage.
// Modports: master = pipeline side driving PR3_*, slave = memory stage.
interface mem_stage_wb_reg_if
    import core_pkg::*;
#(
    parameter int W  = WORD_LEN,
    parameter int IL = INSTRUCTION_LEN,
    parameter int PL = PC_LEN
);
    logic [W-1:0]  PR3_alu_out;
    logic [W-1:0]  PR3_store_data;
    logic [IL-1:0] PR3_instruction;
    logic          PR3_MEM_write;
    logic          PR3_MEM_read;
    logic          PR3_sel_RF_write_src_ALU;
    logic          PR3_sel_RF_write_src_MEM;
    logic          PR3_RF_write_en;
    logic          PR3_push_stack;
    logic          PR3_pop_stack;
    logic [PL-1:0] PR3_return_pc;

    logic [PL-1:0] stack_top_pc;
    logic          stack_overflow;
    logic          stack_underflow;
    logic [W-1:0]  PR4_wb_data;
    logic          PR4_RF_write_en;
    logic [IL-1:0] PR4_instruction;

    modport master (
        output PR3_alu_out, PR3_store_data, PR3_instruction, PR3_MEM_write,
               PR3_MEM_read, PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM,
               PR3_RF_write_en, PR3_push_stack, PR3_pop_stack, PR3_return_pc,
        input  stack_top_pc, stack_overflow, stack_underflow,
               PR4_wb_data, PR4_RF_write_en, PR4_instruction
    );

    modport slave (
        input  PR3_alu_out, PR3_store_data, PR3_instruction, PR3_MEM_write,
               PR3_MEM_read, PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM,
               PR3_RF_write_en, PR3_push_stack, PR3_pop_stack, PR3_return_pc,
        output stack_top_pc, stack_overflow, stack_underflow,
               PR4_wb_data, PR4_RF_write_en, PR4_instruction
    );
endinterface : mem_stage_wb_reg_if

// File: rtl/mem_stage_wb_reg_return_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
// Latency: push/pop take effect at the edge; top is combinational from state.
// Backpressure: none; an illegal push/pop is dropped and flagged.
// Ports: clk, rst (sync, high), push, pop, din (address to push),
//        top (current top or 0 when empty), overflow, underflow.
module return_stack
    import core_pkg::*;
#(
    parameter int PL    = PC_LEN,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [PL-1:0] din,
    output logic [PL-1:0] top,
    output logic          overflow,
    output logic          underflow
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;   // count spans 0..DEPTH inclusive

    logic [PL-1:0] entry [DEPTH];
    logic [CW-1:0] count;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic          empty;
    logic          full;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_idx  = IW'(count - CW'(1));
    assign push_idx = IW'(count);
    assign top      = empty ? '0 : entry[top_idx];

    // Storage is deliberately left out of reset; only count and flags clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push && pop) begin
            if (!empty) begin
                entry[top_idx] <= din;
            end else begin
                // Pop on empty still flags, but the push half goes through.
                entry[0]  <= din;
                count     <= CW'(1);
                underflow <= 1'b1;
            end
        end else if (push) begin
            if (!full) begin
                entry[push_idx] <= din;
                count           <= count + CW'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                count <= count - CW'(1);
            end else begin
                underflow <= 1'b1;
            end
        end
    end
endmodule : return_stack

// File: rtl/mem_stage_wb_reg.sv
// Memory stage: data-memory load/store, return stack, and MEM/WB register.
// Latency: 1 cycle from PR3_* to PR4_*; loads are synchronous with the capture.
// Backpressure: none; every cycle advances.
// Ports: clk, rst (sync, high), bus (mem_stage_wb_reg_if.slave).
module mem_stage_wb_reg
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_stage_wb_reg_if.slave  bus
);
    localparam int MEM_DEPTH = 2 ** ADDR_LEN;

    logic [WORD_LEN-1:0] mem [MEM_DEPTH];
    logic [ADDR_LEN-1:0] addr;
    logic [WORD_LEN-1:0] rd_word;
    logic [WORD_LEN-1:0] wb_next;

    // Upper address bits (if any) are ignored.
    assign addr    = bus.PR3_alu_out[ADDR_LEN-1:0];
    assign rd_word = mem[addr];

    // Memory takes priority when both source selects are set.
    always_comb begin
        wb_next = '0;
        if (bus.PR3_sel_RF_write_src_MEM && bus.PR3_MEM_read) begin
            wb_next = rd_word;
        end else if (bus.PR3_sel_RF_write_src_ALU) begin
            wb_next = bus.PR3_alu_out;
        end
    end

    // Array is not reset; stores are only suppressed while rst is high.
    // rd_word is sampled before this write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!rst && bus.PR3_MEM_write) begin
            mem[addr] <= bus.PR3_store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.PR4_wb_data     <= '0;
            bus.PR4_RF_write_en <= 1'b0;
            bus.PR4_instruction <= '0;
        end else begin
            bus.PR4_wb_data     <= wb_next;
            bus.PR4_RF_write_en <= bus.PR3_RF_write_en;
            bus.PR4_instruction <= bus.PR3_instruction;
        end
    end

    return_stack #(
        .PL    (PC_LEN),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.PR3_push_stack),
        .pop       (bus.PR3_pop_stack),
        .din       (bus.PR3_return_pc),
        .top       (bus.stack_top_pc),
        .overflow  (bus.stack_overflow),
        .underflow (bus.stack_underflow)
    );
endmodule : mem_stage_wb_reg

// File: tb/tb_mem_stage_wb_reg.sv
// Directed bench for the memory stage: reset, load/store, wb select, return stack.
// Latency: checks PR4_* one edge after inputs are presented.
// Backpressure: n/a.
module tb_mem_stage_wb_reg;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_wb_reg_if bus ();

    mem_stage_wb_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.PR3_alu_out              = '0;
        bus.PR3_store_data           = '0;
        bus.PR3_instruction          = '0;
        bus.PR3_MEM_write            = 1'b0;
        bus.PR3_MEM_read             = 1'b0;
        bus.PR3_sel_RF_write_src_ALU = 1'b0;
        bus.PR3_sel_RF_write_src_MEM = 1'b0;
        bus.PR3_RF_write_en          = 1'b0;
        bus.PR3_push_stack           = 1'b0;
        bus.PR3_pop_stack            = 1'b0;
        bus.PR3_return_pc            = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        idle();
        bus.PR3_MEM_write  = 1'b1;
        bus.PR3_alu_out    = a;
        bus.PR3_store_data = d;
    endtask

    task automatic load(input logic [7:0] a);
        idle();
        bus.PR3_MEM_read             = 1'b1;
        bus.PR3_sel_RF_write_src_MEM = 1'b1;
        bus.PR3_alu_out              = a;
    endtask

    task automatic push(input logic [11:0] pc);
        idle();
        bus.PR3_push_stack = 1'b1;
        bus.PR3_return_pc  = pc;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Known value at 0x10, then a reset cycle that tries to overwrite it.
        store(8'h10, 8'h55);
        tick();
        rst = 1'b1;
        store(8'h10, 8'hAA);
        bus.PR3_sel_RF_write_src_ALU = 1'b1;
        bus.PR3_RF_write_en          = 1'b1;
        bus.PR3_instruction          = 19'h7FFFF;
        bus.PR3_push_stack           = 1'b1;
        bus.PR3_return_pc            = 12'h123;
        tick();
        rst = 1'b0;
        chk("rst_wb_data", 32'(bus.PR4_wb_data), 32'h0);
        chk("rst_we", 32'(bus.PR4_RF_write_en), 32'h0);
        chk("rst_instr", 32'(bus.PR4_instruction), 32'h0);
        chk("rst_ovf", 32'(bus.stack_overflow), 32'h0);
        chk("rst_unf", 32'(bus.stack_underflow), 32'h0);
        chk("rst_count", 32'(dut.u_stack.count), 32'h0);
        chk("rst_top", 32'(bus.stack_top_pc), 32'h0);
        load(8'h10);
        tick();
        chk("rst_store_suppressed", 32'(bus.PR4_wb_data), 32'h55);

        // Store then load.
        store(8'h21, 8'h5C);
        bus.PR3_instruction = 19'h12345;
        tick();
        chk("store_instr", 32'(bus.PR4_instruction), 32'h12345);
        chk("store_wb_zero", 32'(bus.PR4_wb_data), 32'h0);
        load(8'h21);
        bus.PR3_RF_write_en = 1'b1;
        tick();
        chk("load_data", 32'(bus.PR4_wb_data), 32'h5C);
        chk("load_we", 32'(bus.PR4_RF_write_en), 32'h1);

        // Same-address read and write: old data is returned.
        store(8'h30, 8'h11);
        tick();
        load(8'h30);
        bus.PR3_MEM_write  = 1'b1;
        bus.PR3_store_data = 8'h22;
        tick();
        chk("rbw_old", 32'(bus.PR4_wb_data), 32'h11);
        load(8'h30);
        tick();
        chk("rbw_new", 32'(bus.PR4_wb_data), 32'h22);

        // ALU path and priority.
        store(8'h7F, 8'h03);
        bus.PR3_sel_RF_write_src_ALU = 1'b1;
        tick();
        chk("alu_path", 32'(bus.PR4_wb_data), 32'h7F);
        load(8'h7F);
        bus.PR3_sel_RF_write_src_ALU = 1'b1;
        tick();
        chk("mem_priority", 32'(bus.PR4_wb_data), 32'h03);
        idle();
        bus.PR3_alu_out              = 8'h7F;
        bus.PR3_sel_RF_write_src_ALU = 1'b1;
        bus.PR3_sel_RF_write_src_MEM = 1'b1;
        tick();
        chk("sel_mem_no_read", 32'(bus.PR4_wb_data), 32'h7F);

        // Stack fill and overflow.
        for (int i = 1; i <= 8; i++) begin
            push(12'(i));
            tick();
        end
        chk("fill_top", 32'(bus.stack_top_pc), 32'h008);
        chk("fill_count", 32'(dut.u_stack.count), 32'd8);
        chk("fill_ovf", 32'(bus.stack_overflow), 32'h0);
        push(12'h009);
        tick();
        chk("ovf_top", 32'(bus.stack_top_pc), 32'h008);
        chk("ovf_count", 32'(dut.u_stack.count), 32'd8);
        chk("ovf_flag", 32'(bus.stack_overflow), 32'h1);
        for (int i = 8; i >= 1; i--) begin
            idle();
            bus.PR3_pop_stack = 1'b1;
            #1;
            chk($sformatf("pop_%0d", i), 32'(bus.stack_top_pc), 32'(i));
            tick();
        end
        chk("empty_top", 32'(bus.stack_top_pc), 32'h0);
        chk("empty_unf", 32'(bus.stack_underflow), 32'h0);
        idle();
        bus.PR3_pop_stack = 1'b1;
        tick();
        chk("unf_flag", 32'(bus.stack_underflow), 32'h1);
        chk("unf_top", 32'(bus.stack_top_pc), 32'h0);
        chk("unf_count", 32'(dut.u_stack.count), 32'd0);
        chk("ovf_sticky", 32'(bus.stack_overflow), 32'h1);

        // Push+pop together.
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'h0);
        push(12'h050);
        tick();
        push(12'h0A0);
        tick();
        chk("pp_pre_top", 32'(bus.stack_top_pc), 32'h0A0);
        push(12'h0B0);
        bus.PR3_pop_stack = 1'b1;
        tick();
        chk("pp_top", 32'(bus.stack_top_pc), 32'h0B0);
        chk("pp_count", 32'(dut.u_stack.count), 32'd2);
        idle();
        bus.PR3_pop_stack = 1'b1;
        tick();
        chk("pp_below", 32'(bus.stack_top_pc), 32'h050);
        tick();
        chk("pp_drained", 32'(dut.u_stack.count), 32'd0);
        chk("pp_unf_clear", 32'(bus.stack_underflow), 32'h0);
        push(12'h0B0);
        bus.PR3_pop_stack = 1'b1;
        tick();
        chk("pp0_count", 32'(dut.u_stack.count), 32'd1);
        chk("pp0_top", 32'(bus.stack_top_pc), 32'h0B0);
        chk("pp0_unf", 32'(bus.stack_underflow), 32'h1);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule : tb_mem_stage_wb_reg
